// File: rtl/demux1x2_4b.sv
// Receive-side 1:2 demultiplexer: steers a valid-qualified word stream into two
// independent per-lane FIFOs selected by `selector`, with a sticky drop flag.
module demux1x2_4b #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              selector,
    input  logic              pop_0,
    input  logic              pop_1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              full_0,
    output logic              full_1,
    output logic              overflow_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem    [2][DEPTH];
    logic [AW-1:0]     r_wr_ptr [2];
    logic [AW-1:0]     r_rd_ptr [2];
    logic [AW:0]       r_count  [2];
    logic              r_overflow;

    logic [1:0] w_push;
    logic [1:0] w_pop_req;
    logic [1:0] w_rd_en;
    logic [1:0] w_wr_en;
    logic [1:0] w_drop;
    logic [1:0] w_full;
    logic [1:0] w_empty;

    assign w_push    = {valid_in & selector, valid_in & ~selector};
    assign w_pop_req = {pop_1, pop_0};

    always_comb begin
        w_rd_en = '0;
        w_wr_en = '0;
        w_drop  = '0;
        w_full  = '0;
        w_empty = '0;
        for (int l = 0; l < 2; l++) begin
            w_full[l]  = (r_count[l] == FULL_CNT);
            w_empty[l] = (r_count[l] == '0);
            w_rd_en[l] = w_pop_req[l] & ~w_empty[l];
            // A pop in the same cycle frees the slot, so a full lane still accepts.
            w_wr_en[l] = w_push[l] & (~w_full[l] | w_rd_en[l]);
            w_drop[l]  = w_push[l] & w_full[l] & ~w_rd_en[l];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_L) begin
            for (int l = 0; l < 2; l++) begin
                r_wr_ptr[l] <= '0;
                r_rd_ptr[l] <= '0;
                r_count[l]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[l][e] <= '0;
                end
            end
            r_overflow <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (w_wr_en[l]) begin
                    r_mem[l][r_wr_ptr[l]] <= data_in;
                    r_wr_ptr[l]           <= r_wr_ptr[l] + AW'(1);
                end
                if (w_rd_en[l]) begin
                    r_rd_ptr[l] <= r_rd_ptr[l] + AW'(1);
                end
                case ({w_wr_en[l], w_rd_en[l]})
                    2'b10:   r_count[l] <= r_count[l] + (AW + 1)'(1);
                    2'b01:   r_count[l] <= r_count[l] - (AW + 1)'(1);
                    default: r_count[l] <= r_count[l];
                endcase
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign valid_out0   = ~w_empty[0];
    assign valid_out1   = ~w_empty[1];
    assign full_0       = w_full[0];
    assign full_1       = w_full[1];
    assign data_out0    = w_empty[0] ? '0 : r_mem[0][r_rd_ptr[0]];
    assign data_out1    = w_empty[1] ? '0 : r_mem[1][r_rd_ptr[1]];
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_demux1x2_4b.sv
// Scoreboard bench for demux1x2_4b: the driver predicts post-edge outputs from a
// queue-based lane model; a separate monitor compares them after each edge.
module tb_demux1x2_4b;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset_L;
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              selector;
    logic              pop_0;
    logic              pop_1;
    logic [DATA_W-1:0] data_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out0;
    logic              valid_out1;
    logic              full_0;
    logic              full_1;
    logic              overflow_err;

    demux1x2_4b #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .selector     (selector),
        .pop_0        (pop_0),
        .pop_1        (pop_1),
        .data_out0    (data_out0),
        .data_out1    (data_out1),
        .valid_out0   (valid_out0),
        .valid_out1   (valid_out1),
        .full_0       (full_0),
        .full_1       (full_1),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d0;
        logic [3:0] d1;
        logic       v0;
        logic       v1;
        logic       f0;
        logic       f1;
        logic       ovf;
        string      tag;
    } snap_t;

    snap_t      exp_q[$];
    logic [3:0] mq[2][$];
    logic       m_ovf;
    int         errors;
    int         checks;

    task automatic check(input string name, input string tag, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s] at %0t: got %h, expected %h", name, tag, $time, act, exp);
        end
    endtask

    // Monitor: one predicted snapshot per driven cycle, compared just after the edge.
    always begin
        snap_t s;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check("valid_out0", s.tag, {3'b0, valid_out0}, {3'b0, s.v0});
            check("valid_out1", s.tag, {3'b0, valid_out1}, {3'b0, s.v1});
            check("data_out0", s.tag, data_out0, s.d0);
            check("data_out1", s.tag, data_out1, s.d1);
            check("full_0", s.tag, {3'b0, full_0}, {3'b0, s.f0});
            check("full_1", s.tag, {3'b0, full_1}, {3'b0, s.f1});
            check("overflow_err", s.tag, {3'b0, overflow_err}, {3'b0, s.ovf});
        end
    end

    task automatic drive(input string tag, input logic rst, input logic vin, input logic sel,
                         input logic [3:0] din, input logic p0, input logic p1);
        snap_t s;
        logic  pops[2];
        @(negedge clk);
        reset_L  = rst;
        valid_in = vin;
        selector = sel;
        data_in  = din;
        pop_0    = p0;
        pop_1    = p1;
        pops[0]  = p0;
        pops[1]  = p1;
        if (rst) begin
            mq[0].delete();
            mq[1].delete();
            m_ovf = 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                int  n;
                logic pop_ok;
                n      = mq[l].size();
                pop_ok = pops[l] && (n > 0);
                if (pop_ok) void'(mq[l].pop_front());
                if (vin && (int'(sel) == l)) begin
                    if (n < DEPTH || pop_ok) mq[l].push_back(din);
                    else m_ovf = 1'b1;
                end
            end
        end
        s.v0  = mq[0].size() > 0;
        s.v1  = mq[1].size() > 0;
        s.d0  = s.v0 ? mq[0][0] : 4'h0;
        s.d1  = s.v1 ? mq[1][0] : 4'h0;
        s.f0  = mq[0].size() == DEPTH;
        s.f1  = mq[1].size() == DEPTH;
        s.ovf = m_ovf;
        s.tag = tag;
        exp_q.push_back(s);
    endtask

    task automatic push(input string tag, input logic sel, input logic [3:0] d);
        drive(tag, 1'b0, 1'b1, sel, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input logic p0, input logic p1);
        drive(tag, 1'b0, 1'b0, 1'($urandom), 4'($urandom), p0, p1);
    endtask

    task automatic do_reset(input string tag);
        drive(tag, 1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        m_ovf    = 1'b0;
        reset_L  = 1'b1;
        valid_in = 1'b0;
        selector = 1'b0;
        data_in  = '0;
        pop_0    = 1'b0;
        pop_1    = 1'b0;

        do_reset("reset");
        do_reset("reset");

        push("alt", 1'b0, 4'hA);
        push("alt", 1'b1, 4'h5);
        push("alt", 1'b0, 4'h3);
        idle("alt_pop0", 1'b1, 1'b0);
        idle("alt_drain", 1'b1, 1'b1);

        for (int i = 1; i <= 4; i++) push("fill", 1'b0, 4'(i));
        push("overflow", 1'b0, 4'h5);
        for (int i = 0; i < 5; i++) idle("drain", 1'b1, 1'b0);

        do_reset("reset2");
        for (int i = 1; i <= 4; i++) push("fill2", 1'b0, 4'(i));
        drive("push_pop_full", 1'b0, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle("wrap_drain", 1'b1, 1'b0);

        idle("pop_empty1", 1'b0, 1'b1);
        drive("push_pop_empty1", 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
        drive("pop0_push1", 1'b0, 1'b1, 1'b1, 4'h8, 1'b1, 1'b1);

        push("mid", 1'b0, 4'hC);
        for (int i = 0; i < 5; i++) push("mid_ovf", 1'b1, 4'(i + 2));
        drive("reset_mid", 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
        push("post_reset", 1'b1, 4'h6);
        idle("post_reset_idle", 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic rst;
            rst = ($urandom_range(0, 79) == 0);
            drive("random", rst, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  4'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
        end

        idle("final", 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1x2_4b.md
# demux1x2_4b

Inverse of the team's 2:1 4-bit mux. Takes one interleaved 4-bit valid-qualified stream and steers each word to one of two output lanes by `selector`. Each lane buffers words in a 4-entry FIFO until its consumer pops it. Sits on the receive side of the mux link, so the original two streams can be recovered and compared lane by lane in the probador benches.

## Interface
Parameters:
- `DATA_W`, 4: word width.
- `DEPTH`, 4: entries per lane FIFO; power of two, at least 2.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `reset_L`  input  1  synchronous, active-high reset (1 = reset, sampled on `clk`).
- `data_in`  input  DATA_W  incoming word.
- `valid_in`  input  1  `data_in` is valid this cycle.
- `selector`  input  1  destination lane for the current word: 0 goes to lane 0, 1 goes to lane 1.
- `pop_0`, `pop_1`  input  1  consumer takes the head word of lane 0 / lane 1.
- `data_out0`, `data_out1`  output  DATA_W  head word of each lane; 0 when the lane is empty.
- `valid_out0`, `valid_out1`  output  1  lane is non-empty.
- `full_0`, `full_1`  output  1  lane holds DEPTH words.
- `overflow_err`  output  1  sticky: at least one word was dropped.

## Operation
- Each lane has a storage array, write pointer, read pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and a count (log2(DEPTH)+1 bits, 0..DEPTH).
- **Push:** `valid_in`=1 pushes `data_in` into the lane chosen by `selector`. The other lane sees no push. `valid_in`=0 ignores `data_in` and `selector`.
- **Pop:** `pop_N`=1 with count_N>0 advances rd_ptr_N. Pop on an empty lane is ignored, with no state change and no error.
- **Push and pop in the same cycle on one lane:**
  - Both happen.
  - Count is unchanged.
  - This is allowed even when full (pop frees the slot that cycle).
  - When empty, the pop is ignored and the push occurs, so count goes to 1.
- **Push to a full lane without a pop that cycle:** the word is dropped, pointers and count are unchanged, and `overflow_err` is set to 1. It stays 1 until reset.
- The two lanes are independent. A pop on one lane and a push to the other in the same cycle both take effect.
- Outputs are derived from registered state only:
  - `valid_outN` = (count_N != 0).
  - `full_N` = (count_N == DEPTH).
  - `data_outN` = mem_N[rd_ptr_N] when valid, else 0.
- **Reset** (`reset_L`=1 at an edge):
  - Pointers, counts, storage and `overflow_err` are cleared to 0.
  - Reset overrides any push or pop in the same cycle.
  - Words in flight are discarded.
  - After reset: `valid_out0`/`valid_out1`=0, `data_out0`/`data_out1`=0, `full_0`/`full_1`=0, `overflow_err`=0.

## Timing
- Push latency is 1 cycle. A word sampled at edge k appears on `data_outN`, with `valid_outN`=1, after edge k if the lane was empty. Otherwise it appears after the preceding words are popped.
- Pop takes effect at the edge. The next word (or 0 with valid=0) is visible after that edge.
- `full_N` rises after the edge of the DEPTH-th outstanding push. It falls after the first edge with a pop and no push.
- `overflow_err` rises after the edge of the dropped push.
- Throughput: one push and one pop per lane per cycle. No combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `reset_L`=1 for 2 cycles with random inputs. Required: all outputs 0, `valid_out*`=0, `full_*`=0.
- **Alternating routing:** push 4'hA (sel 0), 4'h5 (sel 1), 4'h3 (sel 0), no pops.
  - Lane 0 head is A, count 2.
  - Lane 1 head is 5.
  - Popping lane 0 once shows 3.
- **Fill and overflow:** push 1, 2, 3, 4 to lane 0, then 5. Required:
  - `full_0`=1 after the 4th push.
  - 5 is dropped and `overflow_err`=1.
  - 4 pops yield 1, 2, 3, 4, then `valid_out0`=0 and `data_out0`=0.
- **Push+pop at full:** lane 0 full with 1–4; push 9 with `pop_0`=1. Required:
  - Head becomes 2.
  - Count stays 4 and `overflow_err` stays 0.
  - Later pops give 3, 4, 9 (pointer wraps).
- **Pop on empty and simultaneous lanes:**
  - `pop_1` on empty lane 1: no change.
  - Same cycle as push 7 to lane 1 with `pop_1`=1 while lane 1 is empty: `data_out1`=7, `valid_out1`=1.
- **Reset mid-operation:** both lanes partially filled with `overflow_err`=1; assert reset with push and pop active. Required:
  - Everything is 0 after the edge.
  - After release, a fresh push of 6 to lane 1 appears next cycle.
